// File: rtl/sp_ram_ctrl.sv
// Purpose: parametrised single-port RAM with per-byte write enables and a clear engine that initialises every word.
// Latency: read data and rd_valid appear 1 cycle after an accepted access, or 2 cycles when OUT_REG=1.
// Backpressure: no handshake; busy is high while the clear engine runs and every access in that window is dropped.
module sp_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RW_MODE    = 0,
    parameter int OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    write_en,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    clear_req,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [ADDR_WIDTH-1:0]   ptr_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    wr_accept;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    // First output stage: the word returned by the most recent accepted access.
    logic [DATA_WIDTH-1:0]   s1_dat;
    logic                    s1_vld;

    assign busy      = (state_q == ST_CLEAR);
    // A clear request in IDLE wins over any access in the same cycle.
    assign accept    = en && !busy && !clear_req;
    assign wr_accept = accept && write_en;
    assign old_word  = mem[ram_addr];

    // Overlay the enabled byte lanes of data_in onto the currently stored word.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Clear engine state register; reset always restarts the sweep from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear engine next state: sweep every word once, then serve accesses until a new clear request.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage array: clear writes take the single port while busy, otherwise accepted byte-masked writes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr_q] <= CLEAR_VAL;
        end else if (wr_accept) begin
            mem[ram_addr] <= merged_word;
        end
    end

    // First output stage: capture old or merged word per RW_MODE; only reads raise the valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= accept && !write_en;
            if (accept) begin
                s1_dat <= (write_en && (RW_MODE != 0)) ? merged_word : old_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_dat;
        logic                  s2_vld;

        // Extra output register: copies the first stage one cycle later, so it also holds when idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_dat <= '0;
                s2_vld <= 1'b0;
            end else begin
                s2_dat <= s1_dat;
                s2_vld <= s1_vld;
            end
        end

        assign data_out = s2_dat;
        assign rd_valid = s2_vld;
    end else begin : g_out_direct
        assign data_out = s1_dat;
        assign rd_valid = s1_vld;
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Purpose: self-checking bench for sp_ram_ctrl across RW_MODE / OUT_REG / CLEAR_VAL variants and the 8-bit default build.
// Latency: compares every instance one time unit after each rising edge against a behavioural model.
// Backpressure: stimulus is shared by all instances; busy windows are modelled as dropped accesses.
module tb_sp_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        write_en = 1'b0;
    logic [1:0]  byte_en = 2'b00;
    logic [5:0]  ram_addr = '0;
    logic [15:0] data_in = '0;
    logic        clear_req = 1'b0;

    logic [15:0] dout [4];
    logic [3:0]  vld;
    logic [3:0]  bsy;
    logic [7:0]  dout8;
    logic        vld8;
    logic        bsy8;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: memory contents seen by CLEAR_VAL=0 and CLEAR_VAL=FFFF builds.
    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];
    int          clr_left;
    logic [15:0] s1_d [4];
    logic        s1_v [4];
    logic [15:0] o_d  [4];
    logic        o_v  [4];

    always #5 clk = ~clk;

    // Instance g: RW_MODE = g%2, OUT_REG = g/2, CLEAR_VAL = FFFF for the OUT_REG builds.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sp_ram_ctrl #(
            .DATA_WIDTH (16),
            .ADDR_WIDTH (6),
            .RW_MODE    (g % 2),
            .OUT_REG    (g / 2),
            .CLEAR_VAL  ((g / 2) != 0 ? 16'hFFFF : 16'h0000)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .write_en  (write_en),
            .byte_en   (byte_en),
            .ram_addr  (ram_addr),
            .data_in   (data_in),
            .clear_req (clear_req),
            .data_out  (dout[g]),
            .rd_valid  (vld[g]),
            .busy      (bsy[g])
        );
    end

    sp_ram_ctrl u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .write_en  (write_en),
        .byte_en   (byte_en[0]),
        .ram_addr  (ram_addr),
        .data_in   (data_in[7:0]),
        .clear_req (clear_req),
        .data_out  (dout8),
        .rd_valid  (vld8),
        .busy      (bsy8)
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        clr_left = 64;
        for (int i = 0; i < 4; i++) begin
            s1_d[i] = '0;
            s1_v[i] = 1'b0;
            o_d[i]  = '0;
            o_v[i]  = 1'b0;
        end
    endtask

    // One clock of the reference: clear sweep has priority, then clear request, then the access.
    task automatic model_step();
        logic        acc;
        logic [15:0] oldw;
        logic [15:0] prev_d;
        logic        prev_v;
        acc = 1'b0;
        if (clr_left > 0) begin
            mem0[64 - clr_left] = 16'h0000;
            mem1[64 - clr_left] = 16'hFFFF;
            clr_left--;
        end else if (clear_req) begin
            clr_left = 64;
        end else begin
            acc = en;
        end
        for (int i = 0; i < 4; i++) begin
            oldw   = (i >= 2) ? mem1[ram_addr] : mem0[ram_addr];
            prev_d = s1_d[i];
            prev_v = s1_v[i];
            s1_v[i] = acc && !write_en;
            if (acc) begin
                s1_d[i] = (write_en && (i % 2 == 1)) ? merge(oldw, data_in, byte_en) : oldw;
            end
            if (i >= 2) begin
                o_d[i] = prev_d;
                o_v[i] = prev_v;
            end else begin
                o_d[i] = s1_d[i];
                o_v[i] = s1_v[i];
            end
        end
        if (acc && write_en) begin
            mem0[ram_addr] = merge(mem0[ram_addr], data_in, byte_en);
            mem1[ram_addr] = merge(mem1[ram_addr], data_in, byte_en);
        end
    endtask

    task automatic check_outputs();
        logic exp_busy;
        exp_busy = (clr_left > 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d%0d_data", i), dout[i], o_d[i]);
            chk($sformatf("d%0d_valid", i), {15'b0, vld[i]}, {15'b0, o_v[i]});
            chk($sformatf("d%0d_busy", i), {15'b0, bsy[i]}, {15'b0, exp_busy});
        end
        chk("d8_data", {8'h00, dout8}, {8'h00, o_d[0][7:0]});
        chk("d8_valid", {15'b0, vld8}, {15'b0, o_v[0]});
        chk("d8_busy", {15'b0, bsy8}, {15'b0, exp_busy});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic drive(input logic e, input logic w, input logic [1:0] be,
                         input logic [5:0] a, input logic [15:0] d, input logic c);
        en        = e;
        write_en  = w;
        byte_en   = be;
        ram_addr  = a;
        data_in   = d;
        clear_req = c;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
        drive(1'b1, 1'b1, be, a, d, 1'b0);
        step();
    endtask

    task automatic rd(input logic [5:0] a);
        drive(1'b1, 1'b0, 2'($urandom), a, 16'($urandom), 1'b0);
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 6'($urandom), 16'($urandom), 1'b0);
        step();
    endtask

    // Asynchronous reset check: outputs must drop before any clock edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    // Count cycles until busy falls; random accesses during the sweep must be ignored.
    task automatic wait_clear(input string tag, input bit rand_acc);
        int cnt;
        cnt = 0;
        do begin
            if (rand_acc) begin
                drive(1'b1, 1'($urandom), 2'($urandom), 6'($urandom), 16'($urandom), 1'($urandom));
            end else begin
                drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
            end
            step();
            cnt++;
        end while (bsy[0] && cnt < 200);
        chk(tag, 16'(cnt), 16'd64);
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();
        wait_clear("t1_busy_len", 1'b0);

        // Post-clear contents.
        rd(6'd0);
        chk("t1_rd0_d0", dout[0], 16'h0000);
        rd(6'd2);
        rd(6'd7);
        rd(6'd63);
        chk("t1_rd2_d2", dout[2], 16'hFFFF);
        idle();
        idle();

        // Writes then back-to-back reads; the OUT_REG builds lag by one cycle.
        wr(6'd0, 16'h0010, 2'b11);
        chk("t2_wr_novalid", {15'b0, vld[0]}, 16'h0000);
        wr(6'd2, 16'h0011, 2'b11);
        wr(6'd7, 16'h0020, 2'b11);
        rd(6'd0);
        chk("t2_rd0", dout[0], 16'h0010);
        rd(6'd2);
        chk("t2_rd2", dout[0], 16'h0011);
        chk("t5_lat_rd0", dout[2], 16'h0010);
        rd(6'd7);
        chk("t2_rd7", dout[0], 16'h0020);
        chk("t5_lat_rd2", dout[2], 16'h0011);
        idle();
        chk("t5_lat_rd7", dout[2], 16'h0020);
        chk("t5_lat_vld", {15'b0, vld[2]}, 16'h0001);
        idle();

        // Byte enables.
        wr(6'd5, 16'hAABB, 2'b11);
        wr(6'd5, 16'h1234, 2'b01);
        rd(6'd5);
        chk("t3_bytes", dout[0], 16'hAA34);
        wr(6'd5, 16'h9999, 2'b00);
        chk("t3_be0_rw1", dout[1], 16'hAA34);
        rd(6'd5);
        chk("t3_be0_keep", dout[0], 16'hAA34);

        // Read-during-write modes, then write-then-read.
        wr(6'd3, 16'h0055, 2'b11);
        wr(6'd3, 16'h0066, 2'b11);
        chk("t4_rw0", dout[0], 16'h0055);
        chk("t4_rw1", dout[1], 16'h0066);
        rd(6'd3);
        chk("t4_after", dout[0], 16'h0066);
        idle();

        // Randomised traffic on a narrow address window with occasional clear requests.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom),
                  16'($urandom), ($urandom_range(0, 99) == 0));
            step();
        end
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
        while (bsy[0] && n_total < 100000) step();
        idle();

        // Clear request with a colliding access; accesses during the sweep are ignored.
        wr(6'd9, 16'h4242, 2'b11);
        drive(1'b1, 1'b1, 2'b11, 6'd9, 16'h1111, 1'b1);
        step();
        chk("t6_busy_rise", {15'b0, bsy[0]}, 16'h0001);
        wait_clear("t6_clear_len", 1'b1);
        rd(6'd9);
        rd(6'd0);
        chk("t6_rd9_d0", dout[0], 16'h0000);
        rd(6'd7);
        chk("t6_rd9_ff", dout[2], 16'hFFFF);
        idle();
        idle();

        // Reset in the middle of a sweep restarts it from word 0.
        wr(6'd4, 16'hBEEF, 2'b11);
        rd(6'd4);
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
        step();
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
        repeat (20) step();
        do_reset();
        chk("t6_rst_data", dout[0], 16'h0000);
        chk("t6_rst_busy", {15'b0, bsy[0]}, 16'h0001);
        wait_clear("t6_restart_len", 1'b0);
        for (int n = 0; n < 8; n++) begin
            rd(6'($urandom_range(0, 9)));
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
